// File: rtl/mem_bus_arbiter.sv
// Shares one data-memory slave port between NUM_MASTERS requesters and routes
// each response back to its issuing master through an in-order outstanding FIFO.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int OUTSTANDING = 2,
  parameter bit RR_EN       = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_MASTERS-1:0]   m_req_i,
  input  logic [NUM_MASTERS*32-1:0] m_addr_i,
  input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0]   m_we_i,
  input  logic [NUM_MASTERS*4-1:0] m_be_i,
  output logic [NUM_MASTERS-1:0]   m_gnt_o,
  output logic [NUM_MASTERS-1:0]   m_rvalid_o,
  output logic [31:0]              m_rdata_o,
  output logic                     s_req_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  output logic                     s_we_o,
  output logic [3:0]               s_be_o,
  input  logic                     s_gnt_i,
  input  logic                     s_rvalid_i,
  input  logic [31:0]              s_rdata_i,
  output logic                     busy_o,
  output logic                     rsp_err_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);

  logic [IW-1:0]          fifo_q [OUTSTANDING];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   lock;
  logic [IW-1:0]          lock_idx, rr_last;
  logic                   full, hs, pop;
  logic [NUM_MASTERS-1:0] cand;
  logic [IW-1:0]          fp_sel, rr_sel, rr_idx, sel;
  int                     rr_pos;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (count == CW'(OUTSTANDING));
  assign cand = m_req_i & {NUM_MASTERS{~full}};

  always_comb begin
    fp_sel = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (cand[k]) fp_sel = IW'(k);
  end

  // Walk downward so the candidate closest after rr_last is the one kept.
  always_comb begin
    rr_sel = '0;
    rr_pos = 0;
    rr_idx = '0;
    for (int j = NUM_MASTERS; j >= 1; j--) begin
      rr_pos = (int'(rr_last) + j) % NUM_MASTERS;
      rr_idx = IW'(rr_pos);
      if (cand[rr_idx]) rr_sel = rr_idx;
    end
  end

  assign sel     = lock ? lock_idx : (RR_EN ? rr_sel : fp_sel);
  assign s_req_o = (|cand) | lock;
  assign hs      = s_req_o & s_gnt_i;
  assign pop     = s_rvalid_i & (count != '0);

  always_comb begin
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (s_req_o && sel == IW'(k)) begin
        s_addr_o   = m_addr_i[32*k +: 32];
        s_wdata_o  = m_wdata_i[32*k +: 32];
        s_we_o     = m_we_i[k];
        s_be_o     = m_be_i[4*k +: 4];
        m_gnt_o[k] = s_gnt_i;
      end
      if (pop && fifo_q[rd_ptr] == IW'(k)) m_rvalid_o[k] = 1'b1;
    end
  end

  assign m_rdata_o = s_rvalid_i ? s_rdata_i : '0;
  assign rsp_err_o = s_rvalid_i & (count == '0);
  assign busy_o    = (count != '0);

  always_ff @(posedge clk) begin
    if (hs) fifo_q[wr_ptr] <= sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      rr_last  <= IW'(NUM_MASTERS - 1);
    end else begin
      if (hs) begin
        wr_ptr <= ptr_inc(wr_ptr);
        if (RR_EN) rr_last <= sel;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (hs && !pop)      count <= count + 1'b1;
      else if (!hs && pop) count <= count - 1'b1;
      // Hold the presented master until the slave accepts it.
      if (hs) lock <= 1'b0;
      else if (s_req_o && !lock) begin
        lock     <= 1'b1;
        lock_idx <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed-priority and a round-robin instance share
// stimulus; a queue-based model checks both every cycle, plus literal spot checks.
module tb_mem_bus_arbiter;
  localparam int NM   = 3;
  localparam int OUTS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_req    = '0;
  logic [NM*32-1:0] m_addr   = {32'hA000_0200, 32'hA000_0104, 32'hA000_0008};
  logic [NM*32-1:0] m_wdata  = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
  logic [NM-1:0]    m_we     = 3'b010;
  logic [NM*4-1:0]  m_be     = {4'b1111, 4'b0011, 4'b0001};
  logic             s_gnt    = 1'b0;
  logic             s_rvalid = 1'b0;
  logic [31:0]      s_rdata  = '0;

  logic [NM-1:0] gnt_d   [2];
  logic [NM-1:0] rv_d    [2];
  logic [31:0]   rdata_d [2];
  logic [31:0]   saddr_d [2];
  logic [31:0]   swdat_d [2];
  logic          sreq_d  [2];
  logic          swe_d   [2];
  logic [3:0]    sbe_d   [2];
  logic          busy_d  [2];
  logic          err_d   [2];

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(.NUM_MASTERS(NM), .OUTSTANDING(OUTS), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_we_i(m_we), .m_be_i(m_be),
    .m_gnt_o(gnt_d[0]), .m_rvalid_o(rv_d[0]), .m_rdata_o(rdata_d[0]),
    .s_req_o(sreq_d[0]), .s_addr_o(saddr_d[0]), .s_wdata_o(swdat_d[0]), .s_we_o(swe_d[0]),
    .s_be_o(sbe_d[0]), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .busy_o(busy_d[0]), .rsp_err_o(err_d[0])
  );

  mem_bus_arbiter #(.NUM_MASTERS(NM), .OUTSTANDING(OUTS), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_we_i(m_we), .m_be_i(m_be),
    .m_gnt_o(gnt_d[1]), .m_rvalid_o(rv_d[1]), .m_rdata_o(rdata_d[1]),
    .s_req_o(sreq_d[1]), .s_addr_o(saddr_d[1]), .s_wdata_o(swdat_d[1]), .s_we_o(swe_d[1]),
    .s_be_o(sbe_d[1]), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .busy_o(busy_d[1]), .rsp_err_o(err_d[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: outstanding transactions as a queue of master indices.
  int q [2][$];
  int lk [2];
  int lki [2];
  int rrl [2];

  task automatic model_check(input int i);
    int sel, idx;
    bit sreq, hs, pop, full;
    logic [NM-1:0] e_gnt, e_rv;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic e_we, e_err;
    logic [3:0] e_be;
    string p;
    p = (i == 0) ? "fp" : "rr";
    if (!rst_n) begin
      q[i].delete();
      lk[i]  = 0;
      rrl[i] = NM - 1;
    end
    full = (q[i].size() == OUTS);
    sreq = 1'b0;
    sel  = 0;
    if (lk[i] != 0) begin
      sreq = 1'b1;
      sel  = lki[i];
    end else if (!full) begin
      if (i == 0) begin
        for (int k = NM - 1; k >= 0; k--)
          if (m_req[k]) begin sel = k; sreq = 1'b1; end
      end else begin
        for (int j = NM; j >= 1; j--) begin
          idx = (rrl[i] + j) % NM;
          if (m_req[idx]) begin sel = idx; sreq = 1'b1; end
        end
      end
    end
    hs      = sreq && s_gnt;
    e_gnt   = '0;
    if (hs) e_gnt[sel] = 1'b1;
    e_addr  = sreq ? m_addr[sel*32 +: 32] : 32'h0;
    e_wdata = sreq ? m_wdata[sel*32 +: 32] : 32'h0;
    e_we    = sreq ? m_we[sel] : 1'b0;
    e_be    = sreq ? m_be[sel*4 +: 4] : 4'h0;
    pop     = s_rvalid && (q[i].size() > 0);
    e_rv    = '0;
    if (pop) e_rv[q[i][0]] = 1'b1;
    e_err   = s_rvalid && (q[i].size() == 0);
    e_rdata = s_rvalid ? s_rdata : 32'h0;

    chk({"gnt_", p},    32'(gnt_d[i]),   32'(e_gnt));
    chk({"sreq_", p},   32'(sreq_d[i]),  32'(sreq));
    chk({"saddr_", p},  saddr_d[i],      e_addr);
    chk({"swdata_", p}, swdat_d[i],      e_wdata);
    chk({"swe_", p},    32'(swe_d[i]),   32'(e_we));
    chk({"sbe_", p},    32'(sbe_d[i]),   32'(e_be));
    chk({"rvalid_", p}, 32'(rv_d[i]),    32'(e_rv));
    chk({"rdata_", p},  rdata_d[i],      e_rdata);
    chk({"busy_", p},   32'(busy_d[i]),  32'(q[i].size() != 0));
    chk({"rsperr_", p}, 32'(err_d[i]),   32'(e_err));

    if (rst_n) begin
      if (pop) void'(q[i].pop_front());
      if (hs) begin
        q[i].push_back(sel);
        if (i == 1) rrl[i] = sel;
        lk[i] = 0;
      end else if (sreq && lk[i] == 0) begin
        lk[i]  = 1;
        lki[i] = sel;
      end
    end
  endtask

  always @(negedge clk) begin
    model_check(0);
    model_check(1);
  end

  task automatic cyc(input logic [NM-1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    m_req    = req;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_rdata  = rd;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  logic [NM-1:0] rr_exp [6];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_gnt",   32'(gnt_d[0]),  32'h0);
    chk("rst_sreq",  32'(sreq_d[0]), 32'h0);
    chk("rst_busy",  32'(busy_d[0]), 32'h0);
    chk("rst_err",   32'(err_d[0]),  32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(3'b000, 1'b0, 1'b0, 32'h0);

    // rvalid with nothing outstanding
    cyc(3'b000, 1'b0, 1'b1, 32'h1234_5678);
    chk("empty_err",  32'(err_d[0]),  32'h1);
    chk("empty_rv",   32'(rv_d[0]),   32'h0);
    chk("empty_busy", 32'(busy_d[0]), 32'h0);
    cyc(3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_pulse", 32'(err_d[0]), 32'h0);

    // fixed priority grant and response routing
    cyc(3'b110, 1'b1, 1'b0, 32'h0);
    chk("fp_gnt",   32'(gnt_d[0]), 32'h2);
    chk("fp_addr",  saddr_d[0],    32'hA000_0104);
    chk("fp_wdata", swdat_d[0],    32'hC0DE_0001);
    cyc(3'b000, 1'b0, 1'b0, 32'h0);
    chk("fp_busy",  32'(busy_d[0]), 32'h1);
    cyc(3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("fp_rv",    32'(rv_d[0]), 32'h2);
    chk("fp_rdata", rdata_d[0],   32'hDEAD_BEEF);

    // lock keeps M2 presented while M0 arrives
    cyc(3'b100, 1'b0, 1'b0, 32'h0);
    chk("lk_addr0", saddr_d[0], 32'hA000_0200);
    cyc(3'b101, 1'b0, 1'b0, 32'h0);
    chk("lk_addr1", saddr_d[0], 32'hA000_0200);
    chk("lk_nognt", 32'(gnt_d[0]), 32'h0);
    cyc(3'b101, 1'b0, 1'b0, 32'h0);
    chk("lk_addr2", saddr_d[1], 32'hA000_0200);
    cyc(3'b101, 1'b1, 1'b0, 32'h0);
    chk("lk_gnt2", 32'(gnt_d[0]), 32'h4);
    cyc(3'b101, 1'b1, 1'b0, 32'h0);
    chk("lk_gnt0", 32'(gnt_d[0]), 32'h1);
    cyc(3'b000, 1'b0, 1'b1, 32'h1111_1111);
    chk("lk_rv2", 32'(rv_d[0]), 32'h4);
    cyc(3'b000, 1'b0, 1'b1, 32'h2222_2222);
    chk("lk_rv0",    32'(rv_d[0]), 32'h1);
    chk("lk_rdata0", rdata_d[0],   32'h2222_2222);
    cyc(3'b000, 1'b0, 1'b0, 32'h0);

    // fill to OUTSTANDING, then blocked until a pop registers
    cyc(3'b110, 1'b1, 1'b0, 32'h0);
    chk("full_g1", 32'(gnt_d[0]), 32'h2);
    cyc(3'b100, 1'b1, 1'b0, 32'h0);
    chk("full_g2", 32'(gnt_d[0]), 32'h4);
    cyc(3'b001, 1'b1, 1'b0, 32'h0);
    chk("full_sreq", 32'(sreq_d[0]), 32'h0);
    cyc(3'b001, 1'b1, 1'b1, 32'h3333_3333);
    chk("full_rv1",   32'(rv_d[0]),   32'h2);
    chk("full_sreq2", 32'(sreq_d[0]), 32'h0);
    cyc(3'b001, 1'b1, 1'b0, 32'h0);
    chk("full_g3", 32'(gnt_d[0]), 32'h1);
    cyc(3'b000, 1'b0, 1'b1, 32'h4444_4444);
    chk("full_rv2", 32'(rv_d[0]), 32'h4);
    cyc(3'b000, 1'b0, 1'b1, 32'h5555_5555);
    chk("full_rv0", 32'(rv_d[0]), 32'h1);
    cyc(3'b000, 1'b0, 1'b0, 32'h0);
    chk("full_idle", 32'(busy_d[0]), 32'h0);

    // reset with two outstanding
    cyc(3'b110, 1'b1, 1'b0, 32'h0);
    cyc(3'b110, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 1'b0, 1'b0, 32'h0);
    chk("mid_busy", 32'(busy_d[0]), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy_fp", 32'(busy_d[0]), 32'h0);
    chk("mid_rst_busy_rr", 32'(busy_d[1]), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_sreq", 32'(sreq_d[0]), 32'h0);
    cyc(3'b000, 1'b0, 1'b1, 32'hBAD0_0001);
    chk("mid_err", 32'(err_d[0]), 32'h1);
    chk("mid_rv",  32'(rv_d[0]),  32'h0);
    cyc(3'b000, 1'b0, 1'b0, 32'h0);

    // round-robin rotation with back-to-back responses
    for (int e = 0; e < 6; e++) begin
      cyc(3'b111, 1'b1, (e > 0), 32'h5000_0000 + 32'(e));
      chk("rr_gnt", 32'(gnt_d[1]), 32'(rr_exp[e]));
      chk("rr_fp_gnt", 32'(gnt_d[0]), 32'h1);
      if (e > 0) chk("rr_rv", 32'(rv_d[1]), 32'(rr_exp[e-1]));
    end
    cyc(3'b000, 1'b0, 1'b1, 32'h5000_0006);
    chk("rr_rv_last", 32'(rv_d[1]), 32'h4);
    cyc(3'b000, 1'b0, 1'b0, 32'h0);
    cyc(3'b000, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
